// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-counter width for a given word length.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Enable-gated bit counter with synchronous clear; saturates at WIDTH-1.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  assign tc_c = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_ser_tx.sv
// Parallel-in/serial-out transmitter: one word per valid/ready handshake,
// one bit per en tick, framed by sd_frame/sd_last, done pulse per frame.
module piso_ser_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             sd_out,
  output logic             sd_frame,
  output logic             sd_last,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n;
  logic [CNT_W-1:0]   cnt;
  logic               tc_c;
  logic               load;
  logic               cnt_clr, cnt_inc;
  logic               out_n, frame_n, last_n, done_n;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_w(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Combinational from en in SHIFT so the next word can load on the last tick.
  assign s_ready = !rst && ((state == ST_IDLE) || (en && tc_c));
  assign load    = s_valid && s_ready;

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .tc_c (tc_c)
  );

  always_comb begin
    state_n = state;
    sr_n    = sr;
    out_n   = sd_out;
    frame_n = sd_frame;
    last_n  = sd_last;
    done_n  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state)
      ST_IDLE: begin
        out_n   = 1'b0;
        frame_n = 1'b0;
        last_n  = 1'b0;
        if (load) begin
          state_n = ST_SHIFT;
          sr_n    = s_data;
          out_n   = first_bit(s_data);
          frame_n = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (en && !tc_c) begin
          sr_n    = shift_w(sr);
          out_n   = first_bit(shift_w(sr));
          cnt_inc = 1'b1;
          last_n  = (cnt == CNT_W'(WIDTH - 2));
        end else if (en) begin
          // Last bit consumed: chain straight into a new word if one is offered.
          done_n = 1'b1;
          last_n = 1'b0;
          if (load) begin
            sr_n    = s_data;
            out_n   = first_bit(s_data);
            frame_n = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_n = ST_IDLE;
            sr_n    = '0;
            out_n   = 1'b0;
            frame_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      sd_out   <= 1'b0;
      sd_frame <= 1'b0;
      sd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      sd_out   <= out_n;
      sd_frame <= frame_n;
      sd_last  <= last_n;
      done     <= done_n;
    end
  end

endmodule
